// File: rtl/player_bullet.sv
// Player projectile: spawns above the player on fire, climbs once per frame,
// retires on hit or screen top, then waits out a frame cooldown.
// Ports:
//   clk, rst, arst     clock, async active-high resets (ORed)
//   frame              one-cycle pulse per video frame
//   fire, hit          fire request, collision pulse
//   player_x/_y        player sprite left/top edge
//   bullet_x/_y        bullet left/top edge
//   bullet_active      bullet on screen and collidable
//   hit_ack            one-cycle acknowledge of an accepted hit
//   shots_fired        bullets spawned, wraps at 256
module player_bullet #(
  parameter int SPRITE_W        = 32,
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 8,
  parameter int BULLET_STEP     = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arst,
  input  logic       frame,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       hit_ack,
  output logic [7:0] shots_fired
);

  localparam int CW =
    (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [9:0] X_OFF = 10'(SPRITE_W / 2 - BULLET_W / 2);
  localparam logic [9:0] Y_OFF = 10'(BULLET_H);
  localparam logic [9:0] STEP  = 10'(BULLET_STEP);
  localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] CD_ONE  = CW'(1);
  localparam bit HAS_CD = (COOLDOWN_FRAMES > 0);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  state_t        state;
  logic          fire_req;
  logic [CW-1:0] cd_cnt;

  always_ff @(posedge clk or posedge rst or posedge arst) begin
    if (rst || arst) begin
      state         <= IDLE;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= 1'b0;
      hit_ack       <= 1'b0;
      shots_fired   <= '0;
      fire_req      <= 1'b0;
      cd_cnt        <= '0;
    end else begin
      hit_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame && (fire_req || fire)) begin
            bullet_x      <= player_x + X_OFF;
            bullet_y      <= player_y - Y_OFF;
            bullet_active <= 1'b1;
            shots_fired   <= shots_fired + 8'd1;
            fire_req      <= 1'b0;
            state         <= FLYING;
          end else if (fire) begin
            fire_req <= 1'b1;
          end
        end
        FLYING: begin
          // hit wins over frame; position freezes on retirement
          if (hit || (frame && bullet_y < STEP)) begin
            bullet_active <= 1'b0;
            hit_ack       <= hit;
            if (HAS_CD) begin
              state  <= COOLDOWN;
              cd_cnt <= CD_INIT;
            end else begin
              state <= IDLE;
            end
          end else if (frame) begin
            bullet_y <= bullet_y - STEP;
          end
        end
        COOLDOWN: begin
          if (frame) begin
            if (cd_cnt <= CD_ONE) begin
              cd_cnt <= '0;
              state  <= IDLE;
            end else begin
              cd_cnt <= cd_cnt - CD_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: default cooldown instance plus a
// zero-cooldown instance sharing the same stimulus.
module tb_player_bullet;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arst = 1'b0;
  logic       frame = 1'b0;
  logic       fire = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] player_x = '0;
  logic [9:0] player_y = '0;

  logic [9:0] bx, by, bx2, by2;
  logic       act, ack, act2, ack2;
  logic [7:0] shots, shots2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  player_bullet dut (
    .clk(clk), .rst(rst), .arst(arst),
    .frame(frame), .fire(fire), .hit(hit),
    .player_x(player_x), .player_y(player_y),
    .bullet_x(bx), .bullet_y(by),
    .bullet_active(act), .hit_ack(ack),
    .shots_fired(shots)
  );

  player_bullet #(.COOLDOWN_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .arst(arst),
    .frame(frame), .fire(fire), .hit(hit),
    .player_x(player_x), .player_y(player_y),
    .bullet_x(bx2), .bullet_y(by2),
    .bullet_active(act2), .hit_ack(ack2),
    .shots_fired(shots2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
  endtask

  task automatic pulse_fire();
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_active_held", {31'd0, act}, 0);
    rst = 1'b0;
    cyc();
    chk("rst_x", {22'd0, bx}, 0);
    chk("rst_y", {22'd0, by}, 0);
    chk("rst_active", {31'd0, act}, 0);
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_shots", {24'd0, shots}, 0);
    pulse_frame();
    chk("frame_nofire", {31'd0, act}, 0);

    // spawn with fire 10 cycles ahead of frame
    player_x = 10'd300;
    player_y = 10'd440;
    pulse_fire();
    repeat (9) cyc();
    pulse_frame();
    chk("spawn_x", {22'd0, bx}, 315);
    chk("spawn_y", {22'd0, by}, 432);
    chk("spawn_active", {31'd0, act}, 1);
    chk("spawn_shots", {24'd0, shots}, 1);

    repeat (5) pulse_frame();
    chk("flight_y5", {22'd0, by}, 412);
    player_x = 10'd100;
    pulse_frame();
    chk("flight_x_hold", {22'd0, bx}, 315);
    chk("flight_y6", {22'd0, by}, 408);
    pulse_fire();
    pulse_frame();
    pulse_fire();
    chk("flight_shots", {24'd0, shots}, 1);
    chk("flight_y7", {22'd0, by}, 404);

    // hit between frames
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    chk("hit_active", {31'd0, act}, 0);
    chk("hit_ack", {31'd0, ack}, 1);
    chk("hit_y_hold", {22'd0, by}, 404);
    chk("hit_x_hold", {22'd0, bx}, 315);
    cyc();
    chk("hit_ack_once", {31'd0, ack}, 0);

    // cooldown: fire and hit are ignored
    for (int i = 0; i < 8; i++) begin
      pulse_fire();
      pulse_frame();
      chk("cd_no_spawn", {31'd0, act}, 0);
    end
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    chk("cd_hit_no_ack", {31'd0, ack}, 0);
    chk("cd_shots", {24'd0, shots}, 1);
    pulse_fire();
    pulse_frame();
    chk("respawn_active", {31'd0, act}, 1);
    chk("respawn_shots", {24'd0, shots}, 2);
    chk("respawn_x", {22'd0, bx}, 115);
    chk("respawn_y", {22'd0, by}, 432);

    // hit coincident with frame
    @(negedge clk) begin
      hit = 1'b1;
      frame = 1'b1;
    end
    @(negedge clk) begin
      hit = 1'b0;
      frame = 1'b0;
    end
    chk("coinc_y", {22'd0, by}, 432);
    chk("coinc_active", {31'd0, act}, 0);
    chk("coinc_ack", {31'd0, ack}, 1);

    // hit while idle
    pulse_rst();
    @(negedge clk) hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    chk("idle_hit_ack", {31'd0, ack}, 0);
    chk("idle_hit_ack0", {31'd0, ack2}, 0);
    chk("idle_shots", {24'd0, shots}, 0);

    // top exit on both instances
    player_x = 10'd300;
    player_y = 10'd440;
    pulse_fire();
    pulse_frame();
    chk("top_spawn_y", {22'd0, by}, 432);
    chk("top_spawn_y0", {22'd0, by2}, 432);
    repeat (108) pulse_frame();
    chk("top_y0", {22'd0, by}, 0);
    chk("top_active", {31'd0, act}, 1);
    chk("top_y0_cd0", {22'd0, by2}, 0);
    pulse_frame();
    chk("exit_active", {31'd0, act}, 0);
    chk("exit_ack", {31'd0, ack}, 0);
    chk("exit_y", {22'd0, by}, 0);
    chk("exit_active0", {31'd0, act2}, 0);
    chk("exit_ack0", {31'd0, ack2}, 0);
    pulse_fire();
    pulse_frame();
    chk("cd0_respawn", {31'd0, act2}, 1);
    chk("cd0_shots", {24'd0, shots2}, 2);
    chk("cd0_y", {22'd0, by2}, 432);
    chk("cd8_blocked", {31'd0, act}, 0);
    chk("cd8_shots", {24'd0, shots}, 1);

    // async game restart mid-flight
    repeat (3) pulse_frame();
    chk("pre_arst_y", {22'd0, by2}, 420);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("arst_active", {31'd0, act2}, 0);
    chk("arst_shots", {24'd0, shots2}, 0);
    chk("arst_x", {22'd0, bx2}, 0);
    chk("arst_y", {22'd0, by2}, 0);
    chk("arst_shots_cd8", {24'd0, shots}, 0);
    @(negedge clk) arst = 1'b0;
    pulse_frame();
    chk("post_arst_idle", {31'd0, act2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_bullet.md
Name: player_bullet

Overview:
- Owns the single player projectile: accepts a fire request, spawns the bullet centred above the player sprite, and advances it upward once per frame.
- Retires the bullet on a collision hit or when it reaches the top of the screen, then enforces a cooldown before the next shot.
- Consumes `player_x`/`player_y` from the player movement block and `frame` from the display timing.
- Feeds `bullet_x`/`bullet_y`/`bullet_active` to the collision and renderer blocks, and returns `hit_ack` to collision.

Parameters:
- SPRITE_W, 32, scaled player sprite width in pixels.
- BULLET_W, 2, bullet width in pixels.
- BULLET_H, 8, bullet height in pixels.
- BULLET_STEP, 4, upward pixels moved per frame.
- COOLDOWN_FRAMES, 8, frames after retirement before a new fire is accepted (0 allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- arst  in  1  game-restart reset; asynchronous, active-high, ORed with rst.
- frame  in  1  one-cycle pulse per video frame.
- fire  in  1  fire button, level or pulse, any cycle.
- hit  in  1  collision pulse: the bullet struck a target.
- player_x  in  10  player sprite left edge, stable between frames.
- player_y  in  10  player sprite top edge.
- bullet_x  out  10  bullet left edge.
- bullet_y  out  10  bullet top edge.
- bullet_active  out  1  bullet on screen and collidable.
- hit_ack  out  1  one-cycle acknowledge of an accepted hit.
- shots_fired  out  8  count of bullets spawned, wraps at 256.

Behaviour:
- States: IDLE, FLYING, COOLDOWN. All outputs are registered.
- Reset (rst or arst asserted, asynchronous, effective at any time including mid-flight):
  - state IDLE.
  - bullet_x=0, bullet_y=0, bullet_active=0, hit_ack=0, shots_fired=0.
  - fire_req=0, cooldown counter=0.
- fire_req: sticky latch.
  - Set on any cycle with fire=1 while in IDLE.
  - Cleared when consumed, and on any transition out of IDLE.
  - fire asserted in FLYING or COOLDOWN is discarded (no queuing).
- IDLE, on frame with fire_req=1 (or fire=1 in that same cycle), next cycle shows:
  - bullet_x = player_x + SPRITE_W/2 - BULLET_W/2 (10-bit; no overflow for legal player_x ≤ RES_H-SPRITE_W).
  - bullet_y = player_y - BULLET_H.
  - bullet_active=1, shots_fired+1, state FLYING.
- FLYING, hit=1 on any cycle (with or without frame):
  - Next cycle: bullet_active=0 and hit_ack=1 for exactly one cycle.
  - If COOLDOWN_FRAMES>0: state COOLDOWN, counter=COOLDOWN_FRAMES. Otherwise state IDLE.
  - bullet_x/bullet_y hold their last values.
  - Hit has priority over frame: no move on that frame.
- FLYING, frame and no hit:
  - If bullet_y < BULLET_STEP: retire. bullet_active=0, enter COOLDOWN/IDLE exactly as for a hit, but hit_ack stays 0.
  - Otherwise bullet_y -= BULLET_STEP. bullet_x is unchanged.
  - Unsigned arithmetic never wraps.
- Player movement after spawn never affects bullet_x.
- COOLDOWN, on frame:
  - counter==1: counter=0, state IDLE.
  - Otherwise counter-1.
  - hit is ignored; no ack.
- hit is ignored in IDLE and COOLDOWN: hit_ack stays 0.
- hit_ack is high only in the cycle immediately after an accepted hit.

Test Plan:
- Reset: assert rst, then release → all outputs 0, state IDLE. Pulse frame with no fire → bullet_active stays 0.
- Spawn: player_x=300, player_y=440, fire pulsed 10 cycles before frame → after frame, bullet_x=315, bullet_y=432, bullet_active=1, shots_fired=1.
- Flight: 5 further frames → bullet_y=412. Change player_x to 100 → bullet_x stays 315. Fire pulses during flight → no second spawn, shots_fired=1.
- Hit and cooldown: hit pulse between frames → next cycle bullet_active=0 and hit_ack=1 for one cycle.
  - Fire during the 8 cooldown frames is ignored.
  - Fire after the 8th frame → spawn on the following frame, shots_fired=2.
- Top exit: spawn at bullet_y=432 → bullet_y reaches 0 after 108 frames. Next frame bullet_active=0 with hit_ack=0.
  - With COOLDOWN_FRAMES=0, fire is accepted on the very next frame.
- Edge cases:
  - hit coincident with frame while FLYING → bullet_y unchanged, bullet deactivated, ack issued.
  - hit in IDLE → no ack.
  - arst mid-flight → outputs cleared asynchronously, shots_fired=0.
